// File: rtl/vwb_mac_arbiter.sv
// rtl/vwb_mac_arbiter.sv - round-robin scheduler sharing one vwb_mac datapath between requesters
// Grants whole vectors; a 1-stage result register routes each MAC result back to its requester.
module vwb_mac_arbiter #(
    parameter int NumReq      = 2,
    parameter int InVecLength = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 8,
    localparam int Chunks     = InVecLength / WorkingRegs,
    localparam int PW         = (Chunks > 1) ? $clog2(Chunks) : 1,
    localparam int RW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic [NumReq-1:0]                             in_ready,
    input  logic [NumReq-1:0][WorkingRegs-1:0][NBits-1:0] in_data,
    output logic [NumReq-1:0]                             in_pop,
    input  logic [NumReq-1:0]                             out_ready,
    output logic [WorkingRegs-1:0][NBits-1:0]             mac_in_data,
    output logic [PW-1:0]                                 mac_chunk_ptr,
    input  logic [WorkingRegs-1:0][NBits-1:0]             mac_out_data,
    output logic [NumReq-1:0]                             out_push,
    output logic [WorkingRegs-1:0][NBits-1:0]             out_data,
    output logic                                          out_last,
    output logic [RW-1:0]                                 grant_id,
    output logic                                          busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e                           state_q;
    logic [RW-1:0]                    rr_ptr_q;
    logic [RW-1:0]                    grant_q;
    logic [PW-1:0]                    chunk_cnt_q;
    logic [WorkingRegs-1:0][NBits-1:0] mac_in_data_q;
    logic [PW-1:0]                    mac_chunk_ptr_q;
    logic [NumReq-1:0]                out_push_q;
    logic                             out_last_q;

    logic [NumReq-1:0] eligible;
    logic              pick_found;
    logic [RW-1:0]     pick_id;
    logic [RW-1:0]     rr_ptr_d;
    logic              issue;
    logic              last_issue;

    assign eligible   = in_ready & out_ready;
    assign issue      = (state_q == STREAM) && eligible[grant_q];
    assign last_issue = (chunk_cnt_q == PW'(Chunks - 1));

    // Scan from rr_ptr with wrap so the requester just served has lowest priority.
    always_comb begin
        int scan_idx;
        scan_idx   = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = 0; i < NumReq; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= NumReq) begin
                scan_idx = scan_idx - NumReq;
            end
            if (!pick_found && eligible[RW'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_id    = RW'(scan_idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = '0;
        if (int'(pick_id) + 1 < NumReq) begin
            rr_ptr_d = pick_id + 1'b1;
        end
    end

    always_comb begin
        in_pop = '0;
        if (issue) begin
            in_pop[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            grant_q         <= '0;
            chunk_cnt_q     <= '0;
            mac_in_data_q   <= '0;
            mac_chunk_ptr_q <= '0;
            out_push_q      <= '0;
            out_last_q      <= 1'b0;
        end else begin
            out_push_q <= '0;
            out_last_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q     <= pick_id;
                        rr_ptr_q    <= rr_ptr_d;
                        chunk_cnt_q <= '0;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    // Bubbles hold everything, including the grant, until the vector completes.
                    if (issue) begin
                        mac_chunk_ptr_q     <= chunk_cnt_q;
                        mac_in_data_q       <= in_data[grant_q];
                        out_push_q[grant_q] <= 1'b1;
                        out_last_q          <= last_issue;
                        if (last_issue) begin
                            state_q <= IDLE;
                        end else begin
                            chunk_cnt_q <= chunk_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mac_in_data   = mac_in_data_q;
    assign mac_chunk_ptr = mac_chunk_ptr_q;
    assign out_push      = out_push_q;
    assign out_last      = out_last_q;
    assign out_data      = mac_out_data;
    assign grant_id      = grant_q;
    assign busy          = (state_q == STREAM);

endmodule

// File: tb/tb_vwb_mac_arbiter.sv
// tb/tb_vwb_mac_arbiter.sv - scoreboard bench for vwb_mac_arbiter (default and degenerate configs)
`timescale 1ns/1ps
module tb_vwb_mac_arbiter;
    localparam int NR = 2;
    localparam int WR = 4;
    localparam int NB = 8;
    localparam int CH = 4;

    typedef logic [WR-1:0][NB-1:0] chunk_t;
    typedef struct packed {
        chunk_t data;
        logic   last;
    } exp_t;

    logic                        clk_in = 1'b0;
    logic                        rst_in;
    logic [NR-1:0]               in_ready;
    logic [NR-1:0][WR-1:0][NB-1:0] in_data;
    logic [NR-1:0]               in_pop;
    logic [NR-1:0]               out_ready;
    chunk_t                      mac_in_data;
    logic [1:0]                  mac_chunk_ptr;
    chunk_t                      mac_out_data;
    logic [NR-1:0]               out_push;
    chunk_t                      out_data;
    logic                        out_last;
    logic [0:0]                  grant_id;
    logic                        busy;

    logic [0:0]                  d_in_ready;
    logic [0:0][WR-1:0][NB-1:0]  d_in_data;
    logic [0:0]                  d_in_pop;
    logic [0:0]                  d_out_ready;
    chunk_t                      d_mac_in_data;
    logic [0:0]                  d_mac_chunk_ptr;
    chunk_t                      d_mac_out_data;
    logic [0:0]                  d_out_push;
    chunk_t                      d_out_data;
    logic                        d_out_last;
    logic [0:0]                  d_grant_id;
    logic                        d_busy;

    int n_vec = 0;
    int n_err = 0;

    chunk_t fifo0[$];
    chunk_t fifo1[$];
    exp_t   exp0[$];
    exp_t   exp1[$];
    int     push_log[$];
    chunk_t d_fifo[$];
    exp_t   d_exp[$];
    logic [NR-1:0] stall;
    logic [NR-1:0] oready;

    logic [NR-1:0] s_pop, s_push;
    logic          s_last, s_busy;
    logic [1:0]    s_ptr;
    logic [0:0]    s_grant;
    chunk_t        s_data;

    always #5 clk_in = ~clk_in;

    // Reference MAC: weight = chunk address + 2, bias = 1, applied per element.
    always_comb begin
        int t;
        t = 0;
        for (int k = 0; k < WR; k++) begin
            t = int'($signed(mac_in_data[k])) * (int'(mac_chunk_ptr) + 2) + 1;
            mac_out_data[k] = t[7:0];
        end
    end

    always_comb begin
        int t;
        t = 0;
        for (int k = 0; k < WR; k++) begin
            t = int'($signed(d_mac_in_data[k])) * (int'(d_mac_chunk_ptr) + 2) + 1;
            d_mac_out_data[k] = t[7:0];
        end
    end

    vwb_mac_arbiter #(.NumReq(2), .InVecLength(16), .WorkingRegs(4), .NBits(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .in_ready(in_ready), .in_data(in_data), .in_pop(in_pop),
        .out_ready(out_ready),
        .mac_in_data(mac_in_data), .mac_chunk_ptr(mac_chunk_ptr), .mac_out_data(mac_out_data),
        .out_push(out_push), .out_data(out_data), .out_last(out_last),
        .grant_id(grant_id), .busy(busy)
    );

    vwb_mac_arbiter #(.NumReq(1), .InVecLength(4), .WorkingRegs(4), .NBits(8)) dut_deg (
        .clk_in(clk_in), .rst_in(rst_in),
        .in_ready(d_in_ready), .in_data(d_in_data), .in_pop(d_in_pop),
        .out_ready(d_out_ready),
        .mac_in_data(d_mac_in_data), .mac_chunk_ptr(d_mac_chunk_ptr), .mac_out_data(d_mac_out_data),
        .out_push(d_out_push), .out_data(d_out_data), .out_last(d_out_last),
        .grant_id(d_grant_id), .busy(d_busy)
    );

    task automatic update_inputs();
        in_ready[0] = (fifo0.size() > 0) && !stall[0];
        in_ready[1] = (fifo1.size() > 0) && !stall[1];
        in_data[0]  = (fifo0.size() > 0) ? fifo0[0] : '0;
        in_data[1]  = (fifo1.size() > 0) ? fifo1[0] : '0;
        out_ready   = oready;
        d_in_ready[0] = (d_fifo.size() > 0);
        d_in_data[0]  = (d_fifo.size() > 0) ? d_fifo[0] : '0;
        d_out_ready   = 1'b1;
    endtask

    function automatic chunk_t exp_chunk(input chunk_t x, input int c);
        chunk_t r;
        int     t;
        for (int k = 0; k < WR; k++) begin
            t = int'($signed(x[k])) * (c + 2) + 1;
            r[k] = t[7:0];
        end
        return r;
    endfunction

    // Enqueue one vector for requester r and record its expected MAC results.
    task automatic push_vec(input int r, input bit fixed3);
        chunk_t ch;
        exp_t   e;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < WR; k++) begin
                ch[k] = fixed3 ? 8'd3 : 8'($urandom_range(0, 255));
            end
            e.data = exp_chunk(ch, c);
            e.last = (c == CH - 1);
            if (r == 0) begin
                fifo0.push_back(ch);
                exp0.push_back(e);
            end else begin
                fifo1.push_back(ch);
                exp1.push_back(e);
            end
        end
    endtask

    task automatic clear_all();
        fifo0.delete(); fifo1.delete();
        exp0.delete();  exp1.delete();
        d_fifo.delete(); d_exp.delete();
        push_log.delete();
        stall  = '0;
        oready = '1;
        update_inputs();
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        clear_all();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
    endtask

    // One cycle: sample and score at negedge, then advance the FIFO models after the edge.
    task automatic tick();
        logic [NR-1:0] pops;
        exp_t          e;
        @(negedge clk_in);
        s_pop = in_pop; s_push = out_push; s_last = out_last; s_ptr = mac_chunk_ptr;
        s_busy = busy;  s_grant = grant_id; s_data = out_data;
        if (in_pop != '0) begin
            n_vec++;
            if (!busy || in_pop !== (2'b01 << grant_id)) begin
                n_err++;
                $display("FAIL pop_onehot: in_pop=%b grant=%0d busy=%b", in_pop, grant_id, busy);
            end
        end
        for (int r = 0; r < NR; r++) begin
            if (out_push[r]) begin
                push_log.push_back(r);
                n_vec++;
                if ((r == 0 && exp0.size() == 0) || (r == 1 && exp1.size() == 0)) begin
                    n_err++;
                    $display("FAIL sb_unexpected: push on r%0d with no expected entry", r);
                end else begin
                    e = (r == 0) ? exp0.pop_front() : exp1.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        n_err++;
                        $display("FAIL sb_data r%0d: got %h last=%b, want %h last=%b",
                                 r, out_data, out_last, e.data, e.last);
                    end
                end
            end
        end
        pops = in_pop;
        @(posedge clk_in);
        #1;
        if (pops[0] && fifo0.size() > 0) void'(fifo0.pop_front());
        if (pops[1] && fifo1.size() > 0) void'(fifo1.pop_front());
        update_inputs();
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        clear_all();
        push_vec(0, 1'b0);
        update_inputs();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        n_vec++;
        if ({in_pop, out_push, out_last, busy, grant_id} !== '0 || mac_in_data !== '0 || mac_chunk_ptr !== '0) begin
            n_err++;
            $display("FAIL reset_state: pop=%b push=%b last=%b busy=%b grant=%0d x=%h ptr=%0d, want all 0",
                     in_pop, out_push, out_last, busy, grant_id, mac_in_data, mac_chunk_ptr);
        end
    endtask

    task automatic test_single();
        logic [NR-1:0] ep, eu;
        do_reset();
        push_vec(0, 1'b1);
        update_inputs();
        for (int i = 0; i <= 6; i++) begin
            tick();
            ep = (i >= 1 && i <= 4) ? 2'b01 : 2'b00;
            eu = (i >= 2 && i <= 5) ? 2'b01 : 2'b00;
            n_vec++;
            if (s_pop !== ep) begin n_err++; $display("FAIL single_pop c%0d: got %b want %b", i, s_pop, ep); end
            n_vec++;
            if (s_push !== eu) begin n_err++; $display("FAIL single_push c%0d: got %b want %b", i, s_push, eu); end
            n_vec++;
            if (s_last !== (i == 5)) begin n_err++; $display("FAIL single_last c%0d: got %b want %b", i, s_last, (i == 5)); end
            if (i >= 2 && i <= 5) begin
                n_vec++;
                if (s_ptr !== 2'(i - 2)) begin n_err++; $display("FAIL single_ptr c%0d: got %0d want %0d", i, s_ptr, i - 2); end
            end
            if (i == 2) begin
                n_vec++;
                if (s_data[0] !== 8'd7) begin n_err++; $display("FAIL single_mac: got %0d want 7", s_data[0]); end
            end
        end
        n_vec++;
        if (exp0.size() != 0) begin n_err++; $display("FAIL single_drain: %0d results missing", exp0.size()); end
    endtask

    task automatic test_contention();
        int last_cyc;
        int want;
        last_cyc = -1;
        do_reset();
        push_vec(0, 1'b0); push_vec(0, 1'b0);
        push_vec(1, 1'b0); push_vec(1, 1'b0);
        update_inputs();
        for (int i = 0; i <= 22; i++) begin
            tick();
            if (s_push != '0 && s_last) last_cyc = i;
        end
        n_vec++;
        if (push_log.size() != 16) begin
            n_err++;
            $display("FAIL contention_count: got %0d pushes want 16", push_log.size());
        end else begin
            for (int j = 0; j < 16; j++) begin
                want = (j / 4) % 2;
                n_vec++;
                if (push_log[j] != want) begin
                    n_err++;
                    $display("FAIL contention_order push %0d: got r%0d want r%0d", j, push_log[j], want);
                end
            end
        end
        n_vec++;
        if (last_cyc != 20) begin n_err++; $display("FAIL contention_cycles: last push cycle %0d want 20", last_cyc); end
    endtask

    task automatic test_stall();
        do_reset();
        push_vec(0, 1'b0);
        push_vec(1, 1'b0);
        update_inputs();
        for (int i = 0; i <= 16; i++) begin
            tick();
            if (i >= 3 && i <= 5) begin
                n_vec++;
                if (s_pop !== 2'b00 || s_grant !== 1'b0 || !s_busy) begin
                    n_err++;
                    $display("FAIL stall_bubble c%0d: pop=%b grant=%0d busy=%b want 00/0/1", i, s_pop, s_grant, s_busy);
                end
            end
            if (i >= 4 && i <= 6) begin
                n_vec++;
                if (s_push !== 2'b00) begin n_err++; $display("FAIL stall_push c%0d: got %b want 00", i, s_push); end
            end
            if (i == 7) begin
                n_vec++;
                if (s_ptr !== 2'd2) begin n_err++; $display("FAIL stall_resume: ptr %0d want 2", s_ptr); end
            end
            if (i == 2) begin stall[0] = 1'b1; update_inputs(); end
            if (i == 5) begin stall[0] = 1'b0; update_inputs(); end
        end
        n_vec++;
        if (exp0.size() != 0 || exp1.size() != 0 || push_log.size() != 8 || push_log[3] != 0) begin
            n_err++;
            $display("FAIL stall_drain: left r0=%0d r1=%0d pushes=%0d", exp0.size(), exp1.size(), push_log.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        oready[1] = 1'b0;
        push_vec(1, 1'b0);
        update_inputs();
        for (int i = 0; i <= 5; i++) begin
            tick();
            n_vec++;
            if (s_busy !== 1'b0 || s_pop !== 2'b00) begin
                n_err++;
                $display("FAIL bp_blocked c%0d: busy=%b pop=%b want 0/00", i, s_busy, s_pop);
            end
        end
        oready[1] = 1'b1;
        update_inputs();
        tick();
        n_vec++;
        if (s_busy !== 1'b0) begin n_err++; $display("FAIL bp_grant_early: busy=%b want 0", s_busy); end
        tick();
        n_vec++;
        if (s_busy !== 1'b1 || s_grant !== 1'b1 || s_pop !== 2'b10) begin
            n_err++;
            $display("FAIL bp_grant: busy=%b grant=%0d pop=%b want 1/1/10", s_busy, s_grant, s_pop);
        end
        for (int i = 0; i < 20 && exp1.size() != 0; i++) tick();
        n_vec++;
        if (exp1.size() != 0) begin n_err++; $display("FAIL bp_drain: %0d results missing", exp1.size()); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        push_vec(0, 1'b0);
        update_inputs();
        for (int i = 0; i <= 3; i++) tick();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL midop_busy: got %b want 1", busy); end
        #2 rst_in = 1'b0;
        #1;
        n_vec++;
        if ({in_pop, out_push, out_last, busy, grant_id} !== '0 || mac_in_data !== '0 || mac_chunk_ptr !== '0) begin
            n_err++;
            $display("FAIL midop_async: pop=%b push=%b last=%b busy=%b grant=%0d x=%h ptr=%0d, want all 0",
                     in_pop, out_push, out_last, busy, grant_id, mac_in_data, mac_chunk_ptr);
        end
        clear_all();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
        push_vec(0, 1'b0);
        push_vec(1, 1'b0);
        update_inputs();
        for (int i = 0; i <= 11; i++) begin
            tick();
            if (i == 2) begin
                n_vec++;
                if (s_push !== 2'b01 || s_ptr !== 2'd0) begin
                    n_err++;
                    $display("FAIL midop_retry: push=%b ptr=%0d want 01/0", s_push, s_ptr);
                end
            end
        end
        n_vec++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_err++;
            $display("FAIL midop_drain: left r0=%0d r1=%0d", exp0.size(), exp1.size());
        end
    endtask

    task automatic test_degenerate();
        chunk_t ch;
        exp_t   e;
        logic   p, ep, eu;
        do_reset();
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < WR; k++) ch[k] = 8'($urandom_range(0, 255));
            d_fifo.push_back(ch);
            e.data = exp_chunk(ch, 0);
            e.last = 1'b1;
            d_exp.push_back(e);
        end
        update_inputs();
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk_in);
            ep = (i == 1 || i == 3 || i == 5);
            eu = (i == 2 || i == 4 || i == 6);
            n_vec++;
            if (d_in_pop[0] !== ep || d_out_push[0] !== eu) begin
                n_err++;
                $display("FAIL deg_timing c%0d: pop=%b push=%b want %b/%b", i, d_in_pop, d_out_push, ep, eu);
            end
            if (d_out_push[0] && d_exp.size() > 0) begin
                e = d_exp.pop_front();
                n_vec++;
                if (d_out_data !== e.data || d_out_last !== 1'b1) begin
                    n_err++;
                    $display("FAIL deg_data c%0d: got %h last=%b want %h last=1", i, d_out_data, d_out_last, e.data);
                end
            end
            p = d_in_pop[0];
            @(posedge clk_in);
            #1;
            if (p && d_fifo.size() > 0) void'(d_fifo.pop_front());
            update_inputs();
        end
        n_vec++;
        if (d_exp.size() != 0) begin n_err++; $display("FAIL deg_drain: %0d results missing", d_exp.size()); end
    endtask

    initial begin
        stall  = '0;
        oready = '1;
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_backpressure();
        test_reset_midop();
        test_degenerate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
